instr_fetch: RTL and testbench

- Fetch stage of the RV32I core. Holds the PC, issues word requests to instruction memory, and buffers returned instructions with their PCs in a small in-order FIFO.
- Presents instructions to the decode stage (decoder plus immediate generator) over a valid/ready handshake.
- Supports redirects (taken branch, JAL/JALR) by flushing buffered and in-flight fetches.

---
 rtl/instr_fetch.sv | 154 +++++++++++++++
 tb/tb_instr_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC, in-order instruction memory requests, tagged fetch buffer to decode.
// Optional misaligned-redirect fault reporting is enabled by defining FETCH_MISALIGN_CHK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] Nop = 32'h0000_0013;
    localparam logic [CntW:0] Depth = (CntW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic            fault_q, fault_d;

    logic [31:0] buf_instr_q [FIFO_DEPTH];
    logic [31:0] buf_pc_q    [FIFO_DEPTH];
    logic [31:0] tag_q       [FIFO_DEPTH];

    logic        grant, push, pop, drop_rsp, misalign;
    logic [31:0] target_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target_pc = redirect_pc;
    assign misalign  = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign target_pc = {redirect_pc[31:2], 2'b00};
    assign misalign  = 1'b0;
`endif

    // Credit rule: in-flight plus buffered fetches never exceed the buffer size.
    assign imem_req  = !rst && !redirect_en && !fault_q &&
                       (({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < Depth);
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    // Responses are stale while drops are pending or when a redirect lands this cycle.
    assign drop_rsp    = redirect_en || (drop_cnt_q != '0);
    assign push        = imem_rvalid && !drop_rsp;
    assign id_valid    = (fifo_cnt_q != '0);
    assign pop         = id_valid && id_ready && !redirect_en;
    assign id_instr    = id_valid ? buf_instr_q[rd_ptr_q] : Nop;
    assign id_pc       = id_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
    assign fetch_fault = fault_q;

    always_comb begin
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        fault_d    = fault_q;

        if (grant) begin
            pc_d     = pc_q + 32'd4;
            tag_wr_d = tag_wr_q + PtrOne;
        end
        if (imem_rvalid) begin
            tag_rd_d = tag_rd_q + PtrOne;
        end
        case ({grant, imem_rvalid})
            2'b10:   out_cnt_d = out_cnt_q + CntOne;
            2'b01:   out_cnt_d = out_cnt_q - CntOne;
            default: out_cnt_d = out_cnt_q;
        endcase

        if (redirect_en) begin
            // Every fetch still in flight belongs to the old stream.
            pc_d       = target_pc;
            drop_cnt_d = out_cnt_q - CntW'(imem_rvalid);
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fault_d    = misalign;
        end else begin
            if (imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CntOne;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CntOne;
                2'b01:   fifo_cnt_d = fifo_cnt_q - CntOne;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            fault_q    <= fault_d;
        end
    end

    // Storage needs no reset: contents are only observed through the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
        end
        if (grant) begin
            tag_q[tag_wr_q] <= pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch: epoch-based stream model plus directed scenarios.
module tb_instr_fetch;
    localparam int unsigned Depth   = 2;
    localparam logic [31:0] ResetPc = 32'h0000_0100;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc;
    logic        fetch_fault;

    instr_fetch #(.RESET_PC(ResetPc), .FIFO_DEPTH(Depth)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] act; int epoch; } gnt_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    gnt_t gq[$];     // granted, not yet responded (memory + model)
    exp_t exp_q[$];  // instructions the decode stage must see next, in order
    logic [31:0] m_pc;
    bit          m_fault;
    int          epoch;

    bit          ev_grant, ev_resp, ev_redir;
    logic [31:0] ev_addr, ev_target;

    int p_gnt, p_rv, p_rdy, p_redir;
    bit force_redir, combo_arm;
    logic [31:0] force_target, combo_target;

    int n_checks = 0;
    int n_fail = 0;
    bit exp_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_965A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        gq.delete();
        exp_q.delete();
        m_pc = ResetPc;
        m_fault = 1'b0;
        epoch = 0;
        ev_grant = 0; ev_resp = 0; ev_redir = 0;
    endtask

    // Apply the previous cycle's events at the clock edge.
    task automatic apply_events();
        gnt_t g;
        if (ev_resp && gq.size() > 0) begin
            g = gq.pop_front();
            if (!ev_redir && g.epoch == epoch) exp_q.push_back('{pc: g.pc, instr: mem_word(g.pc)});
        end
        if (ev_grant) begin
            gq.push_back('{pc: m_pc, act: ev_addr, epoch: epoch});
            m_pc = m_pc + 32'd4;
        end
        if (ev_redir) begin
            epoch++;
            exp_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
            m_pc = ev_target;
            m_fault = (ev_target[1:0] != 2'b00);
`else
            m_pc = {ev_target[31:2], 2'b00};
            m_fault = 1'b0;
`endif
        end
    endtask

    task automatic drive();
        logic [31:0] t;
        if (gq.size() > 0 && $urandom_range(0, 99) < p_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(gq[0].act);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt    = ($urandom_range(0, 99) < p_gnt);
        id_ready    = ($urandom_range(0, 99) < p_rdy);
        redirect_en = 1'b0;
        redirect_pc = $urandom;
        if (force_redir) begin
            redirect_en = 1'b1; redirect_pc = force_target; force_redir = 0;
        end else if (combo_arm && imem_rvalid && id_ready && exp_q.size() > 0) begin
            redirect_en = 1'b1; redirect_pc = combo_target; combo_arm = 0;
        end else if ($urandom_range(0, 99) < p_redir) begin
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
            redirect_en = 1'b1; redirect_pc = t;
        end
    endtask

    task automatic step();
        @(posedge clk);
        apply_events();
        ev_grant = 0; ev_resp = 0; ev_redir = 0;
        #1;
        drive();
        #1;
        ev_grant  = imem_req && imem_gnt;
        ev_addr   = imem_addr;
        ev_resp   = imem_rvalid;
        ev_redir  = redirect_en;
        ev_target = redirect_pc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; redirect_en = 0; id_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_probs(input int g, input int v, input int r, input int d);
        p_gnt = g; p_rv = v; p_rdy = r; p_redir = d;
    endtask

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        if (rst) begin
            check("rst_imem_req", 32'(imem_req), 32'd0);
            check("rst_id_valid", 32'(id_valid), 32'd0);
            check("rst_id_instr", id_instr, Nop);
            check("rst_id_pc", id_pc, 32'd0);
            check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        end else begin
            exp_req = !redirect_en && !m_fault && (gq.size() + exp_q.size() < Depth);
            check("imem_req", 32'(imem_req), 32'(exp_req));
            if (imem_req) check("imem_addr", imem_addr, m_pc);
            check("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("id_instr", id_instr, exp_q[0].instr);
                check("id_pc", id_pc, exp_q[0].pc);
            end else begin
                check("id_instr_empty", id_instr, Nop);
                check("id_pc_empty", id_pc, 32'd0);
            end
            check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            if (exp_q.size() != 0 && id_ready && !redirect_en) void'(exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        rst = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect_en = 0; redirect_pc = 0;
        id_ready = 0; force_redir = 0; combo_arm = 0;
        set_probs(0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming: grant every cycle, 1-cycle latency, decode always ready.
        set_probs(100, 100, 100, 0);
        run(12);

        // Decode stalled: buffer fills, requests stop, head stays stable, then drains.
        reset_dut();
        set_probs(100, 100, 0, 0);
        run(8);
        set_probs(100, 100, 100, 0);
        run(8);

        // Two fetches outstanding then redirect: both responses must be dropped.
        reset_dut();
        set_probs(100, 0, 100, 0);
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step();
            if (gq.size() == 2) reached = 1;
        end
        check("two_outstanding_reached", 32'(reached), 32'd1);
        force_target = 32'h0000_0200;
        force_redir = 1;
        step();
        set_probs(100, 100, 100, 0);
        run(10);

        // Redirect coinciding with a response and a decode pop.
        combo_target = 32'h0000_0400;
        combo_arm = 1;
        run(12);
        check("combo_redirect_fired", 32'(combo_arm), 32'd0);

        // PC wrap-around.
        force_target = 32'hFFFF_FFF8;
        force_redir = 1;
        run(8);

        // Misaligned redirect, then an aligned one.
        force_target = 32'h0000_0202;
        force_redir = 1;
        run(8);
        force_target = 32'h0000_0300;
        force_redir = 1;
        run(8);

        // Random traffic.
        set_probs(65, 55, 60, 4);
        run(3000);
        set_probs(90, 90, 30, 8);
        run(1500);

        // Mid-operation reset, then random traffic again.
        reset_dut();
        set_probs(70, 60, 70, 5);
        run(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
